// File: rtl/bist_pkg.sv
// Shared definitions for the BIST controller: FSM state encoding and the
// default golden MISR signature.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_CAPTURE,
    ST_FLUSH,
    ST_COMPARE,
    ST_FINISH
  } bist_state_e;

  localparam logic [15:0] DEFAULT_GOLDEN_SIG = 16'hA5C3;

endpackage

// File: rtl/bist_controller.sv
// Scan BIST sequencer: drives an external pattern LFSR and MISR through
// shift/capture cycles, then compares the final signature to a golden value.
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned CHAIN_LEN    = 8,
  parameter int unsigned NUM_PATTERNS = 100,
  parameter logic [15:0] GOLDEN_SIG   = DEFAULT_GOLDEN_SIG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] misr_sig,
  output logic        se,
  output logic        lfsr_en,
  output logic        misr_en,
  output logic        misr_clr,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int PAT_W = $clog2(NUM_PATTERNS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS - 1);

  bist_state_e      state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic             pass_q;

  // COMPARE runs one cycle after the last FLUSH compaction, so misr_sig
  // already holds the final signature when it is latched here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      pat_cnt_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      if (state_q == ST_COMPARE) begin
        pass_q <= (misr_sig == GOLDEN_SIG);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pat_cnt_d = pat_cnt_q;
    se        = 1'b1;
    lfsr_en   = 1'b0;
    misr_en   = 1'b0;
    misr_clr  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        misr_clr  = 1'b1;
        bit_cnt_d = '0;
        pat_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        lfsr_en = 1'b1;
        // The very first load only flushes stale chain contents.
        misr_en = (pat_cnt_q != '0);
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      ST_CAPTURE: begin
        busy      = 1'b1;
        se        = 1'b0;
        lfsr_en   = 1'b1;
        pat_cnt_d = pat_cnt_q + PAT_W'(1);
        state_d   = (pat_cnt_q == LAST_PAT) ? ST_FLUSH : ST_SHIFT;
      end
      ST_FLUSH: begin
        busy    = 1'b1;
        misr_en = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = ST_COMPARE;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      ST_COMPARE: begin
        busy    = 1'b1;
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done = 1'b1;
        if (start) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pass = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: two instances (8x4 and 1x1) checked
// against timing/count formulas and a behavioural MISR stand-in.
module tb_bist_controller;
  import bist_pkg::*;

  localparam int CL_A = 8;
  localparam int NP_A = 4;
  localparam int CL_B = 1;
  localparam int NP_B = 1;
  localparam logic [15:0] GOLDEN = DEFAULT_GOLDEN_SIG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b;
  logic [15:0] misr_a, misr_b;
  logic        se_a, lfsr_en_a, misr_en_a, misr_clr_a, busy_a, done_a, pass_a;
  logic        se_b, lfsr_en_b, misr_en_b, misr_clr_b, busy_b, done_b, pass_b;

  int checks = 0;
  int errors = 0;

  bist_controller #(.CHAIN_LEN(CL_A), .NUM_PATTERNS(NP_A), .GOLDEN_SIG(GOLDEN)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .misr_sig(misr_a),
    .se(se_a), .lfsr_en(lfsr_en_a), .misr_en(misr_en_a), .misr_clr(misr_clr_a),
    .busy(busy_a), .done(done_a), .pass(pass_a)
  );

  bist_controller #(.CHAIN_LEN(CL_B), .NUM_PATTERNS(NP_B), .GOLDEN_SIG(GOLDEN)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .misr_sig(misr_b),
    .se(se_b), .lfsr_en(lfsr_en_b), .misr_en(misr_en_b), .misr_clr(misr_clr_b),
    .busy(busy_b), .done(done_b), .pass(pass_b)
  );

  // Stand-in MISR for instance A: compacts a random scan-out bit when enabled,
  // and can be overridden to present a chosen signature.
  logic [15:0] misr_q_a;
  logic        force_a;
  logic [15:0] force_val_a;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) misr_q_a <= '0;
    else if (misr_clr_a) misr_q_a <= '0;
    else if (misr_en_a)
      misr_q_a <= {misr_q_a[14:0],
                   misr_q_a[15] ^ misr_q_a[13] ^ misr_q_a[12] ^ misr_q_a[10] ^ 1'($urandom)};
  end
  assign misr_a = force_a ? force_val_a : misr_q_a;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit which);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Must be called at a negedge; force_kind 0 = golden, 1 = near-miss, 2 = none.
  task automatic runOnce(input bit which, input int force_kind, input bit inject);
    int cl, np, lat, n, inj_at;
    int se_low, men, lfen, clr, bsy;
    logic o_se, o_lf, o_men, o_clr, o_busy, o_done, o_pass;
    logic [15:0] val, cmp_val;
    logic exp_pass;
    cl = which ? CL_B : CL_A;
    np = which ? NP_B : NP_A;
    lat = 1 + np * (cl + 1) + cl + 1;
    inj_at = inject ? 1 + $urandom_range(cl - 1, 0) : -1;
    val = (force_kind == 0) ? GOLDEN : 16'hA5C2;
    cmp_val = '0;
    se_low = 0; men = 0; lfen = 0; clr = 0; bsy = 0;
    force_a = 1'b0;
    applyStimulus(which);
    n = 0;
    o_done = which ? done_b : done_a;
    while (o_done !== 1'b1 && n < lat + 20) begin
      o_se  = which ? se_b       : se_a;
      o_lf  = which ? lfsr_en_b  : lfsr_en_a;
      o_men = which ? misr_en_b  : misr_en_a;
      o_clr = which ? misr_clr_b : misr_clr_a;
      o_busy = which ? busy_b    : busy_a;
      se_low += (o_se === 1'b0) ? 1 : 0;
      men    += (o_men === 1'b1) ? 1 : 0;
      lfen   += (o_lf === 1'b1) ? 1 : 0;
      clr    += (o_clr === 1'b1) ? 1 : 0;
      bsy    += (o_busy === 1'b1) ? 1 : 0;
      if (n == lat - 1) begin
        if (force_kind < 2) begin
          cmp_val = val;
          if (which) misr_b = val; else begin force_val_a = val; force_a = 1'b1; end
        end else begin
          if (which) begin misr_b = 16'($urandom); cmp_val = misr_b; end
          else cmp_val = misr_q_a;
        end
      end else if (which) begin
        misr_b = 16'($urandom);
      end
      if (which) start_b = (n == inj_at); else start_a = (n == inj_at);
      @(negedge clk);
      n++;
      o_done = which ? done_b : done_a;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    exp_pass = (cmp_val == GOLDEN);
    o_pass = which ? pass_b : pass_a;
    checkOutput("latency", n, lat);
    checkOutput("se_low_cycles", se_low, np);
    checkOutput("misr_en_cycles", men, np * cl);
    checkOutput("lfsr_en_cycles", lfen, np * (cl + 1));
    checkOutput("misr_clr_cycles", clr, 1);
    checkOutput("busy_cycles", bsy, lat);
    checkOutput("pass", o_pass, exp_pass);
    force_a = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("done_held", which ? done_b : done_a, 1);
    checkOutput("busy_finish", which ? busy_b : busy_a, 0);
    checkOutput("se_finish", which ? se_b : se_a, 1);
    checkOutput("pass_held", which ? pass_b : pass_a, exp_pass);
  endtask

  initial begin
    int k, bad;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    force_a = 1'b0; force_val_a = '0; misr_b = '0;
    #1;
    checkOutput("rst_se", se_a, 1);
    checkOutput("rst_lfsr_en", lfsr_en_a, 0);
    checkOutput("rst_misr_en", misr_en_a, 0);
    checkOutput("rst_misr_clr", misr_clr_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_pass", pass_a, 0);
    checkOutput("rst_b_busy", busy_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] golden run, start on first edge after reset");
    runOnce(0, 0, 0);
    $display("[TB] restart from finish with near-miss signature");
    runOnce(0, 1, 0);
    $display("[TB] start pulsed during shift");
    runOnce(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      runOnce(0, $urandom_range(2, 0), 1'($urandom));
    end

    $display("[TB] reset during second pattern");
    applyStimulus(0);
    k = $urandom_range(17, 10);
    repeat (k) @(negedge clk);
    checkOutput("busy_before_abort", busy_a, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_se", se_a, 1);
    checkOutput("abort_lfsr_en", lfsr_en_a, 0);
    checkOutput("abort_misr_en", misr_en_a, 0);
    checkOutput("abort_misr_clr", misr_clr_a, 0);
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_done", done_a, 0);
    checkOutput("abort_pass", pass_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    checkOutput("idle_after_abort", bad, 0);
    runOnce(0, 0, 0);

    $display("[TB] minimal chain and pattern count");
    runOnce(1, 0, 0);
    runOnce(1, 1, 0);
    runOnce(1, 2, 1);
    runOnce(1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter CHAIN_LEN, default 8: scan-chain length in bits; legal range >= 1.
REQ-002 Parameter NUM_PATTERNS, default 100: number of scan patterns applied per run; legal range >= 1.
REQ-003 Parameter GOLDEN_SIG, default 16'hA5C3: expected 16-bit MISR signature.
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 START  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 MISR_SIG  in  16  current MISR register contents.
REQ-008 SE  out  1  scan enable to the circuit under test: 1 = shift, 0 = capture.
REQ-009 LFSR_EN  out  1  advance the pattern LFSR this cycle.
REQ-010 MISR_EN  out  1  compact the scan-out bit into the MISR this cycle.
REQ-011 MISR_CLR  out  1  synchronous clear of the MISR this cycle.
REQ-012 BUSY  out  1  run in progress.
REQ-013 DONE  out  1  run finished and result valid.
REQ-014 PASS  out  1  registered compare result; meaningful only while DONE = 1.

Function
REQ-015 FSM states: IDLE, CLEAR, SHIFT, CAPTURE, FLUSH, COMPARE, FINISH.
REQ-016 IDLE: when START = 1, go to CLEAR; otherwise stay in IDLE.
REQ-017 CLEAR lasts 1 cycle: MISR_CLR = 1, bit counter = 0, pattern counter = 0; then go to SHIFT.
REQ-018 SHIFT lasts exactly CHAIN_LEN cycles with SE = 1 and LFSR_EN = 1; then go to CAPTURE.
REQ-019 MISR_EN = 1 in SHIFT only when pattern counter >= 1; the first load does not compact stale chain contents.
REQ-020 CAPTURE lasts 1 cycle: SE = 0, LFSR_EN = 1, MISR_EN = 0; pattern counter increments.
REQ-021 After CAPTURE: if the incremented count = NUM_PATTERNS, go to FLUSH; otherwise go to SHIFT.
REQ-022 FLUSH lasts CHAIN_LEN cycles with SE = 1, MISR_EN = 1, LFSR_EN = 0, unloading the last response; then go to COMPARE.
REQ-023 COMPARE lasts 1 cycle: PASS register <= (MISR_SIG == GOLDEN_SIG), with the MISR value sampled after the final FLUSH compaction; then go to FINISH.
REQ-024 FINISH: DONE = 1, BUSY = 0, PASS held; START = 1 goes to CLEAR and clears DONE; otherwise stay in FINISH.
REQ-025 BUSY = 1 in states CLEAR through COMPARE inclusive; START is ignored while BUSY = 1.
REQ-026 Latency: from the START sample edge to DONE = 1 is exactly 1 + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles.
REQ-027 Outside SHIFT, CAPTURE and FLUSH, SE = 1 (chain idle-safe), LFSR_EN = 0 and MISR_EN = 0.
REQ-028 Bit counter width is clog2(CHAIN_LEN+1) and pattern counter width is clog2(NUM_PATTERNS+1); neither counter wraps within a run.
REQ-029 CHAIN_LEN = 1 and NUM_PATTERNS = 1 are valid and follow the same state sequence with no skipped states.

Reset
REQ-030 RST_N low forces state IDLE and both counters to 0, and sets outputs to SE = 1, LFSR_EN = 0, MISR_EN = 0, MISR_CLR = 0, BUSY = 0, DONE = 0, PASS = 0, asynchronously.
REQ-031 Reset mid-run aborts the run with no result; after release, a new START is required.
REQ-032 The first START is recognised on the first rising edge after RST_N deasserts.

Structure
REQ-033 State enum and GOLDEN_SIG default value belong in package bist_pkg.
REQ-034 FSM and counters are inline; no sub-module is needed.
REQ-035 The block instantiates no LFSR or MISR; it controls existing instances through LFSR_EN, MISR_EN and MISR_CLR.

Verification
REQ-036 CHAIN_LEN = 8, NUM_PATTERNS = 4, START pulse -> DONE rises 46 cycles later; SE low on exactly 4 cycles; MISR_EN high on exactly 32 cycles.
REQ-037 MISR model forced to GOLDEN_SIG before COMPARE -> PASS = 1; forced to 16'hA5C2 -> PASS = 0.
REQ-038 START pulsed during SHIFT -> no restart; DONE still rises at cycle 46.
REQ-039 RST_N low during pattern 2 -> all outputs at reset values immediately; BUSY = 0; no DONE until a new START.
REQ-040 From FINISH, START -> DONE = 0 next cycle, MISR_CLR = 1 for 1 cycle, full run repeats with the same timing.
REQ-041 CHAIN_LEN = 1, NUM_PATTERNS = 1 -> DONE rises 5 cycles after START.
